md_unit: RTL and testbench



---
 rtl/md_pkg.sv | 22 ++
 rtl/md_neg.sv | 18 +
 rtl/md_unit.sv | 175 +++++++++++++++++
 tb/tb_md_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared constants for the iterative multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package md_pkg;

    // Iteration count equals the operand width (one bit per cycle).
    localparam int ITER = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/md_neg.sv
`default_nettype none
// ============================================================================
//  Module      : md_neg
//  Description : Conditional two's-complement negate.
//  Revision    : 1.0  initial release
// ============================================================================
module md_neg #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    assign o_dout = i_en ? (~i_din + WIDTH'(1)) : i_din;

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative mult/multu/div/divu unit with HI/LO result pair.
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_cnt_w = $clog2(WIDTH);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_araw;
    logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor
    logic [WIDTH-1:0]   r_acc;    // product upper half or partial remainder
    logic [WIDTH-1:0]   r_low;    // multiplier/product low half, or dividend/quotient
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    md_neg #(.WIDTH(WIDTH)) u_abs_a (
        .i_en   (op[0] & a[WIDTH-1]),
        .i_din  (a),
        .o_dout (w_a_abs)
    );

    md_neg #(.WIDTH(WIDTH)) u_abs_b (
        .i_en   (op[0] & b[WIDTH-1]),
        .i_din  (b),
        .o_dout (w_b_abs)
    );

    // Unsigned ops latch raw signs too, so gate the sign fix with the signed bit.
    assign w_neg_q = r_op[0] & (r_sa ^ r_sb);
    assign w_neg_r = r_op[0] & r_sa;

    md_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_en   (w_neg_q),
        .i_din  ({r_acc, r_low}),
        .o_dout (w_prod_fix)
    );

    md_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .i_en   (w_neg_q),
        .i_din  (r_low),
        .o_dout (w_quo_fix)
    );

    md_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .i_en   (w_neg_r),
        .i_din  (r_acc),
        .o_dout (w_rem_fix)
    );

    assign w_mul_sum = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opnd} : '0);

    // Bit WIDTH of the trial difference is the borrow: set means restore.
    assign w_shift = {r_acc, r_low[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_opnd};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bzero <= 1'b0;
            r_araw  <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_low   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CALC;
                        r_op    <= op;
                        r_sa    <= a[WIDTH-1];
                        r_sb    <= b[WIDTH-1];
                        r_bzero <= (b == '0);
                        r_araw  <= a;
                        r_acc   <= '0;
                        r_cnt   <= c_cnt_w'(WIDTH-1);
                        if (op[1]) begin
                            r_opnd <= w_b_abs;
                            r_low  <= w_a_abs;
                        end else begin
                            r_opnd <= w_a_abs;
                            r_low  <= w_b_abs;
                        end
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                S_CALC: begin
                    if (r_op[1]) begin
                        r_acc <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_low <= {r_low[WIDTH-2:0], ~w_trial[WIDTH]};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_low <= {w_mul_sum[0], r_low[WIDTH-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    if (r_op[1]) begin
                        if (r_bzero) begin
                            r_hi <= r_araw;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Directed/random scoreboard bench for md_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] sb_q[$];

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULTU: p = {32'b0, x} * {32'b0, y};
            OP_MULT:  p = 64'(sx * sy);
            default: begin
                if (y == 32'b0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (o == OP_DIVU) begin
                    uq = x / y;
                    ur = x % y;
                    p  = {ur, uq};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [63:0] exp, input int inject, input bit wr_with_start);
        logic [31:0] pre_hi, pre_lo;
        logic [63:0] e;
        int cyc, busy_cnt;
        sb_q.push_back(exp);
        pre_hi = hi;
        pre_lo = lo;
        op = o; a = xa; b = xb; start = 1'b1;
        if (wr_with_start) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom;
        cyc = 0; busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            check("hi_hold", hi, pre_hi);
            check("lo_hold", lo, pre_lo);
            if (cyc == inject) begin
                start = 1'b1; op = ~o; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("latency", 64'(cyc), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("busy_at_done", 64'(busy), 64'd0);
        e = sb_q.pop_front();
        check("hi_result", 64'(hi), 64'(e[63:32]));
        check("lo_result", 64'(lo), 64'(e[31:0]));
        tick();
        check("done_pulse", 64'(done), 64'd0);
        check("no_requeue", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int seen_done;

        rst = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        lo_we = 1'b1; wdata = 32'h0000_1234;
        tick();
        lo_we = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_hi", 64'(hi), 64'd0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo_hi", 64'(hi), 64'hCAFE_F00D);
        check("mthilo_lo", 64'(lo), 64'hCAFE_F00D);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1,  5, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, -1, 1'b1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1, 1'b0);
        run_op(OP_DIVU,  32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, -1, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, -1, 1'b0);
        run_op(OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 10, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i == 2) rb = 32'd0;
            run_op(ro, ra, rb, model(ro, ra, rb), -1, 1'b0);
        end

        // Reset ten cycles into an operation discards it.
        op = OP_MULT; a = 32'd1234; b = 32'd5678; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        seen_done = 0;
        repeat (40) begin
            tick();
            if (done || busy) seen_done++;
        end
        check("midrst_quiet", 64'(seen_done), 64'd0);
        check("midrst_lo_hold", 64'(lo), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
